// File: rtl/sfm_row_sequencer.sv
// Row sequencer for a softmax engine. Each row goes through the same steps:
// an accumulate pass on the input streamer, a wait for the reduction, then a
// divide pass that runs the input and output streamers together.
// The next row's addresses are the current ones advanced by the row stride.
module sfm_row_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_in_i,
  input  logic [ADDR_WIDTH-1:0] base_out_i,
  input  logic [ADDR_WIDTH-1:0] row_stride_i,
  input  logic [LEN_WIDTH-1:0]  row_len_i,
  input  logic [LEN_WIDTH-1:0]  n_rows_i,
  input  logic                  in_done_i,
  input  logic                  out_done_i,
  input  logic                  reducing_i,
  output logic                  in_start_o,
  output logic                  out_start_o,
  output logic [ADDR_WIDTH-1:0] in_addr_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [LEN_WIDTH-1:0]  tot_len_o,
  output logic                  acc_finished_o,
  output logic                  dividing_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  row_idx_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_ACC  = 3'd1,
    ACCUMULATE = 3'd2,
    WAIT_RED   = 3'd3,
    DIVIDE     = 3'd4,
    FINISH     = 3'd5
  } state_e;

  state_e                state_q;
  logic [LEN_WIDTH-1:0]  row_idx_q;
  logic [LEN_WIDTH-1:0]  n_rows_q;
  logic [LEN_WIDTH-1:0]  row_len_q;
  logic [ADDR_WIDTH-1:0] in_addr_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic                  last_row;

  assign last_row = (row_idx_q == (n_rows_q - LEN_WIDTH'(1)));

  // Job state machine and the per-row configuration registers it owns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      row_idx_q  <= '0;
      n_rows_q   <= '0;
      row_len_q  <= '0;
      in_addr_q  <= '0;
      out_addr_q <= '0;
      stride_q   <= '0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      row_idx_q  <= '0;
      n_rows_q   <= '0;
      row_len_q  <= '0;
      in_addr_q  <= '0;
      out_addr_q <= '0;
      stride_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if ((n_rows_i != '0) && (row_len_i != '0)) begin
              n_rows_q   <= n_rows_i;
              row_len_q  <= row_len_i;
              stride_q   <= row_stride_i;
              in_addr_q  <= base_in_i;
              out_addr_q <= base_out_i;
              row_idx_q  <= '0;
              state_q    <= START_ACC;
            end else begin
              // Empty job: report completion without touching the streamers.
              state_q <= FINISH;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        START_ACC: begin
          state_q <= ACCUMULATE;
        end
        ACCUMULATE: begin
          if (in_done_i) begin
            state_q <= WAIT_RED;
          end else begin
            state_q <= ACCUMULATE;
          end
        end
        WAIT_RED: begin
          if (reducing_i) begin
            state_q <= DIVIDE;
          end else begin
            state_q <= WAIT_RED;
          end
        end
        DIVIDE: begin
          if (out_done_i) begin
            if (last_row) begin
              state_q <= FINISH;
            end else begin
              // Address arithmetic wraps modulo 2^ADDR_WIDTH by design.
              row_idx_q  <= row_idx_q + LEN_WIDTH'(1);
              in_addr_q  <= in_addr_q + stride_q;
              out_addr_q <= out_addr_q + stride_q;
              state_q    <= START_ACC;
            end
          end else begin
            state_q <= DIVIDE;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Control strobes decoded from the registered state; they react to the
  // handshake inputs in the same cycle, and clear suppresses starts and done.
  always_comb begin
    in_start_o     = 1'b0;
    out_start_o    = 1'b0;
    acc_finished_o = 1'b0;
    dividing_o     = 1'b0;
    done_o         = 1'b0;
    busy_o         = 1'b1;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
      end
      START_ACC: begin
        in_start_o = ~clear_i;
      end
      ACCUMULATE: begin
        acc_finished_o = in_done_i;
      end
      WAIT_RED: begin
        if (reducing_i) begin
          in_start_o  = ~clear_i;
          out_start_o = ~clear_i;
        end else begin
          acc_finished_o = 1'b1;
        end
      end
      DIVIDE: begin
        dividing_o = ~out_done_i;
      end
      FINISH: begin
        done_o = ~clear_i;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign in_addr_o  = in_addr_q;
  assign out_addr_o = out_addr_q;
  assign tot_len_o  = row_len_q;
  assign row_idx_o  = row_idx_q;

endmodule

// File: tb/tb_sfm_row_sequencer.sv
// Directed bench for sfm_row_sequencer. Inputs follow an open-loop timeline
// with fixed latencies L (start->in_done), R (in_done->reducing) and
// D (divide start->out_done). The expected outputs for every cycle come from
// plain arithmetic on that timeline, and a few literal checks pin the model.
module tb_sfm_row_sequencer;
  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_i, start_i;
  logic [AW-1:0] base_in_i, base_out_i, row_stride_i;
  logic [LW-1:0] row_len_i, n_rows_i;
  logic          in_done_i, out_done_i, reducing_i;
  logic          in_start_o, out_start_o;
  logic [AW-1:0] in_addr_o, out_addr_o;
  logic [LW-1:0] tot_len_o, row_idx_o;
  logic          acc_finished_o, dividing_o, busy_o, done_o;

  int errors = 0;
  int checks = 0;

  logic          cmp_en, chk_addr;
  logic          e_in_start, e_out_start, e_acc, e_div, e_busy, e_done;
  logic [AW-1:0] e_in_addr, e_out_addr;
  logic [LW-1:0] e_len, e_row;

  logic [AW-1:0] inq[$];
  logic [AW-1:0] outq[$];
  logic [AW-1:0] pairq[$];
  int            done_cnt, busy_cnt;

  always #5 clk = ~clk;

  sfm_row_sequencer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .start_i(start_i),
    .base_in_i(base_in_i), .base_out_i(base_out_i), .row_stride_i(row_stride_i),
    .row_len_i(row_len_i), .n_rows_i(n_rows_i),
    .in_done_i(in_done_i), .out_done_i(out_done_i), .reducing_i(reducing_i),
    .in_start_o(in_start_o), .out_start_o(out_start_o),
    .in_addr_o(in_addr_o), .out_addr_o(out_addr_o), .tot_len_o(tot_len_o),
    .acc_finished_o(acc_finished_o), .dividing_o(dividing_o),
    .busy_o(busy_o), .done_o(done_o), .row_idx_o(row_idx_o)
  );

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus event capture for literal checks.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_start", AW'(in_start_o), AW'(e_in_start));
      check("out_start", AW'(out_start_o), AW'(e_out_start));
      check("acc_finished", AW'(acc_finished_o), AW'(e_acc));
      check("dividing", AW'(dividing_o), AW'(e_div));
      check("busy", AW'(busy_o), AW'(e_busy));
      check("done", AW'(done_o), AW'(e_done));
      if (chk_addr) begin
        check("in_addr", in_addr_o, e_in_addr);
        check("out_addr", out_addr_o, e_out_addr);
        check("tot_len", AW'(tot_len_o), AW'(e_len));
        check("row_idx", AW'(row_idx_o), AW'(e_row));
      end
      if (in_start_o && !out_start_o) inq.push_back(in_addr_o);
      if (out_start_o) begin
        outq.push_back(out_addr_o);
        pairq.push_back(in_addr_o);
      end
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
    end
  end

  task automatic clear_log();
    inq.delete();
    outq.delete();
    pairq.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic zero_exp();
    e_in_start = 1'b0; e_out_start = 1'b0; e_acc = 1'b0; e_div = 1'b0;
    e_busy = 1'b0; e_done = 1'b0;
    e_in_addr = '0; e_out_addr = '0; e_len = '0; e_row = '0;
  endtask

  // Runs one job; abort_k > 0 aborts at that cycle via clear (or reset when
  // abort_rst), restart_k > 0 pulses start with unrelated config mid-job.
  task automatic run_job(input logic [AW-1:0] bi, input logic [AW-1:0] bo,
                         input logic [AW-1:0] st, input logic [LW-1:0] rl,
                         input logic [LW-1:0] nr, input int L, input int R,
                         input int D, input int abort_k, input bit abort_rst,
                         input int restart_k);
    int p;
    int last_k;
    int nrows;
    p = L + R + D + 1;
    nrows = ((nr == '0) || (rl == '0)) ? 0 : int'(nr);
    last_k = (abort_k > 0) ? abort_k + 2 : nrows * p + 2;
    cmp_en = 1'b1;
    for (int k = 0; k <= last_k; k++) begin
      int idx, r, o;
      start_i = 1'b0; clear_i = 1'b0; rst_n = 1'b1;
      in_done_i = 1'b0; out_done_i = 1'b0; reducing_i = 1'b0;
      base_in_i = 32'hA5A5_0000; base_out_i = 32'h5A5A_0000;
      row_stride_i = 32'h0000_1000; row_len_i = 16'h0077; n_rows_i = 16'h0009;
      zero_exp();
      chk_addr = 1'b0;
      if (k == 0) begin
        start_i = 1'b1;
        base_in_i = bi; base_out_i = bo; row_stride_i = st;
        row_len_i = rl; n_rows_i = nr;
      end
      if (k == restart_k) start_i = 1'b1;
      if (k >= 1) begin
        idx = k - 1;
        r = idx / p;
        o = idx % p;
        if (r < nrows) begin
          in_done_i  = (o == L) || (o == L + R + 1);
          reducing_i = (o == L + R);
          out_done_i = (o == L + R + D);
          e_busy      = 1'b1;
          e_in_start  = (o == 0) || (o == L + R);
          e_out_start = (o == L + R);
          e_acc       = (o == L) || ((o > L) && (o < L + R));
          e_div       = (o > L + R) && (o < L + R + D);
          e_in_addr   = bi + st * AW'(r);
          e_out_addr  = bo + st * AW'(r);
          e_len       = rl;
          e_row       = LW'(r);
          chk_addr    = 1'b1;
        end else if (idx == nrows * p) begin
          e_busy = 1'b1;
          e_done = 1'b1;
        end
      end
      if (abort_k > 0 && k >= abort_k) begin
        if (k == abort_k && !abort_rst) begin
          clear_i = 1'b1;
          e_in_start = 1'b0; e_out_start = 1'b0; e_done = 1'b0;
        end else begin
          if (k == abort_k) rst_n = 1'b0;
          in_done_i = 1'b0; out_done_i = 1'b0; reducing_i = 1'b0;
          zero_exp();
          chk_addr = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    cmp_en = 1'b0;
  endtask

  initial begin
    cmp_en = 1'b0; chk_addr = 1'b0; zero_exp();
    rst_n = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    base_in_i = '0; base_out_i = '0; row_stride_i = '0;
    row_len_i = '0; n_rows_i = '0;
    in_done_i = 1'b0; out_done_i = 1'b0; reducing_i = 1'b0;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    // Reset state.
    check("rst_busy", AW'(busy_o), 32'd0);
    check("rst_done", AW'(done_o), 32'd0);
    check("rst_in_start", AW'(in_start_o), 32'd0);
    check("rst_in_addr", in_addr_o, 32'd0);
    check("rst_out_addr", out_addr_o, 32'd0);
    check("rst_tot_len", AW'(tot_len_o), 32'd0);
    check("rst_row_idx", AW'(row_idx_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single row.
    clear_log();
    run_job(32'h100, 32'h200, 32'h40, 16'd16, 16'd1, 2, 3, 2, 0, 1'b0, -1);
    check("j1_in_starts", AW'(inq.size()), 32'd1);
    if (inq.size() == 1) check("j1_in_addr", inq[0], 32'h100);
    check("j1_pairs", AW'(outq.size()), 32'd1);
    if (outq.size() == 1) begin
      check("j1_pair_out", outq[0], 32'h200);
      check("j1_pair_in", pairq[0], 32'h100);
    end
    check("j1_done_cnt", AW'(done_cnt), 32'd1);

    // Three rows, minimal latencies.
    clear_log();
    run_job(32'h100, 32'h200, 32'h40, 16'd16, 16'd3, 1, 1, 1, 0, 1'b0, -1);
    check("j3_in_starts", AW'(inq.size()), 32'd3);
    if (inq.size() == 3) begin
      check("j3_in0", inq[0], 32'h100);
      check("j3_in1", inq[1], 32'h140);
      check("j3_in2", inq[2], 32'h180);
    end
    check("j3_pairs", AW'(outq.size()), 32'd3);
    if (outq.size() == 3) begin
      check("j3_out0", outq[0], 32'h200);
      check("j3_out1", outq[1], 32'h240);
      check("j3_out2", outq[2], 32'h280);
    end
    check("j3_done_cnt", AW'(done_cnt), 32'd1);

    // Empty jobs: zero rows, then zero row length.
    clear_log();
    run_job(32'h100, 32'h200, 32'h40, 16'd16, 16'd0, 2, 2, 2, 0, 1'b0, -1);
    check("j0_done_cnt", AW'(done_cnt), 32'd1);
    check("j0_busy_cycles", AW'(busy_cnt), 32'd1);
    check("j0_in_starts", AW'(inq.size() + pairq.size()), 32'd0);
    clear_log();
    run_job(32'h100, 32'h200, 32'h40, 16'd0, 16'd2, 2, 2, 2, 0, 1'b0, -1);
    check("jl0_done_cnt", AW'(done_cnt), 32'd1);
    check("jl0_starts", AW'(inq.size() + pairq.size()), 32'd0);

    // Clear during DIVIDE of row 1 (L=2,R=2,D=3: p=8, divide offset 5 -> k=14).
    clear_log();
    run_job(32'h100, 32'h200, 32'h40, 16'd16, 16'd3, 2, 2, 3, 14, 1'b0, -1);
    check("clr_done_cnt", AW'(done_cnt), 32'd0);
    clear_log();
    run_job(32'h100, 32'h200, 32'h40, 16'd16, 16'd2, 2, 2, 3, 0, 1'b0, -1);
    if (inq.size() > 0) check("after_clr_in0", inq[0], 32'h100);
    else check("after_clr_in_starts", AW'(inq.size()), 32'd2);
    check("after_clr_done", AW'(done_cnt), 32'd1);

    // Clear exactly on the row-1 START_ACC cycle (k = 1 + p).
    clear_log();
    run_job(32'h300, 32'h400, 32'h10, 16'd8, 16'd3, 2, 2, 2, 8, 1'b0, -1);
    check("clr2_in_starts", AW'(inq.size()), 32'd1);
    check("clr2_done_cnt", AW'(done_cnt), 32'd0);

    // Start pulsed during ACCUMULATE with different config.
    clear_log();
    run_job(32'h100, 32'h200, 32'h40, 16'd16, 16'd2, 3, 1, 4, 0, 1'b0, 2);
    check("ign_done_cnt", AW'(done_cnt), 32'd1);
    if (inq.size() == 2) check("ign_in1", inq[1], 32'h140);
    else check("ign_in_starts", AW'(inq.size()), 32'd2);

    // Address wrap.
    clear_log();
    run_job(32'hFFFF_FFC0, 32'h200, 32'h40, 16'd4, 16'd2, 2, 2, 2, 0, 1'b0, -1);
    if (inq.size() == 2) check("wrap_in1", inq[1], 32'h0000_0000);
    else check("wrap_in_starts", AW'(inq.size()), 32'd2);

    // Reset mid-job.
    clear_log();
    run_job(32'h100, 32'h200, 32'h40, 16'd16, 16'd2, 2, 2, 2, 5, 1'b1, -1);
    check("rstab_done_cnt", AW'(done_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
